// File: rtl/serial_mem_responder_pkg.sv
// serial_mem_responder_pkg: link symbols and FSM encodings shared by the serial memory responder.
package serial_mem_responder_pkg;

   localparam int TX_CMD_BITS = 2;
   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 2'd1;
   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 2'd2;
   localparam int RESP_SBS_READ = 1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_HEADER,
      RX_ADDR,
      RX_RD,
      RX_RDCAP,
      RX_WDATA,
      RX_WR
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_DELAY,
      TX_DATA
   } tx_state_t;

endpackage

// File: rtl/serial_mem_responder_fifo.sv
// resp_fifo: synchronous FIFO of read data between receiver and transmitter, no bypass.
module resp_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic         o_full,
   output logic         o_empty,
   output logic [W-1:0] o_head
);

   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_wr;
   logic          w_rd;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      o_full  = r_cnt == CW'(DEPTH);
      o_empty = r_cnt == '0;
      o_head  = r_mem[r_rp];
      w_rd    = i_pop && !o_empty;
      // a pop frees the slot the same cycle, so push-while-full is accepted alongside it
      w_wr    = i_push && (!o_full || w_rd);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) r_wp <= inc(r_wp);
         if (w_rd) r_rp <= inc(r_rp);
         r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= i_data;
   end

endmodule

// File: rtl/serial_mem_responder.sv
// serial_mem_responder: memory-side end of the CPU serial link; decodes commands,
// drives a synchronous memory port and serialises read data back with a start symbol.
module serial_mem_responder
   import serial_mem_responder_pkg::*;
#(
   parameter int IO_BITS        = 2,
   parameter int PAYLOAD_CYCLES = 8,
   parameter int RESP_DELAY     = 0,
   parameter int QUEUE_DEPTH    = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IO_BITS-1:0] cmd_pins,
   output logic [IO_BITS-1:0] resp_pins,
   output logic [15:0]        mem_addr,
   output logic               mem_re,
   input  logic [15:0]        mem_rdata,
   output logic               mem_we,
   output logic [15:0]        mem_wdata,
   output logic               busy,
   output logic               overflow
);

   localparam int CW = PAYLOAD_CYCLES > 1 ? $clog2(PAYLOAD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(PAYLOAD_CYCLES - 1);
   localparam logic [3:0] DLY_M1 = 4'(RESP_DELAY == 0 ? 0 : RESP_DELAY - 1);

   rx_state_t               r_rx;
   rx_state_t               w_rx_next;
   logic [CW-1:0]           r_rx_cnt;
   logic [TX_CMD_BITS-1:0]  r_hdr;
   logic [15:0]             r_sh;
   logic [15:0]             w_sh_next;
   logic [15:0]             r_mem_addr;
   logic [15:0]             r_mem_wdata;
   logic                    w_rx_last;
   logic                    w_push;

   tx_state_t               r_tx;
   tx_state_t               w_tx_next;
   logic [CW-1:0]           r_tx_cnt;
   logic [3:0]              r_dly;
   logic [15:0]             r_tx_sh;
   logic                    w_tx_last;
   logic                    w_start;

   logic                    w_full;
   logic                    w_empty;
   logic [15:0]             w_head;
   logic                    r_ovf;

   resp_fifo #(.DEPTH(QUEUE_DEPTH), .W(16)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (w_push),
      .i_pop  (w_start),
      .i_data (mem_rdata),
      .o_full (w_full),
      .o_empty(w_empty),
      .o_head (w_head)
   );

   always_ff @(posedge clk) begin
      if (reset) r_rx <= RX_IDLE;
      else       r_rx <= w_rx_next;
   end

   always_comb begin
      w_rx_last = r_rx_cnt == LAST;
      w_sh_next = {cmd_pins, r_sh[15:IO_BITS]};
      w_rx_next = r_rx;
      case (r_rx)
         RX_IDLE:   w_rx_next = cmd_pins != '0 ? RX_HEADER : RX_IDLE;
         RX_HEADER: w_rx_next = RX_ADDR;
         RX_ADDR:   w_rx_next = !w_rx_last ? RX_ADDR :
                                r_hdr == TX_HEADER_READ_16  ? RX_RD :
                                r_hdr == TX_HEADER_WRITE_16 ? RX_WDATA : RX_IDLE;
         RX_RD:     w_rx_next = RX_RDCAP;
         RX_RDCAP:  w_rx_next = RX_IDLE;
         RX_WDATA:  w_rx_next = w_rx_last ? RX_WR : RX_WDATA;
         RX_WR:     w_rx_next = RX_IDLE;
         default:   w_rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      mem_re    = r_rx == RX_RD;
      mem_we    = r_rx == RX_WR;
      w_push    = r_rx == RX_RDCAP;
      mem_addr  = r_mem_addr;
      mem_wdata = r_mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) r_rx_cnt <= '0;
      else       r_rx_cnt <= (r_rx == RX_ADDR || r_rx == RX_WDATA) && !w_rx_last ? r_rx_cnt + 1'b1 : '0;
   end

   // address and write data only change once a full word has arrived, and survive reset
   always_ff @(posedge clk) begin
      if (r_rx == RX_HEADER) r_hdr <= cmd_pins[TX_CMD_BITS-1:0];
      if (r_rx == RX_ADDR || r_rx == RX_WDATA) r_sh <= w_sh_next;
      if (r_rx == RX_ADDR && w_rx_last) r_mem_addr <= w_sh_next;
      if (r_rx == RX_WDATA && w_rx_last) r_mem_wdata <= w_sh_next;
   end

   always_ff @(posedge clk) begin
      if (reset) r_tx <= TX_IDLE;
      else       r_tx <= w_tx_next;
   end

   // the start symbol is issued in the cycle the wait ends, so an entry seen in IDLE
   // with no delay goes out at once and consecutive responses need no gap
   always_comb begin
      w_tx_last = r_tx_cnt == LAST;
      w_start   = (r_tx == TX_IDLE && !w_empty && RESP_DELAY == 0) ||
                  (r_tx == TX_DELAY && r_dly == '0);
      w_tx_next = w_start ? TX_DATA :
                  r_tx == TX_IDLE && !w_empty ? TX_DELAY :
                  r_tx == TX_DATA && w_tx_last ? TX_IDLE : r_tx;
   end

   always_comb begin
      resp_pins = w_start ? IO_BITS'(RESP_SBS_READ) :
                  r_tx == TX_DATA ? r_tx_sh[IO_BITS-1:0] : '0;
      busy      = r_rx != RX_IDLE || !w_empty || r_tx != TX_IDLE;
      overflow  = r_ovf;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_cnt <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_tx_cnt <= r_tx == TX_DATA && !w_tx_last ? r_tx_cnt + 1'b1 : '0;
         r_ovf    <= r_ovf || (w_push && w_full && !w_start);
      end
   end

   always_ff @(posedge clk) begin
      r_dly   <= r_tx == TX_DELAY ? r_dly - 4'd1 : DLY_M1;
      r_tx_sh <= w_start ? w_head : r_tx_sh >> IO_BITS;
   end

endmodule

// File: tb/tb_serial_mem_responder.sv
// tb_serial_mem_responder: directed vectors for the serial memory responder,
// three instances with response delays 0, 4 and 15.
module tb_serial_mem_responder;

   logic       clk = 1'b0;
   logic [5:0] cmd_v = '0;
   logic [2:0] rst_v = '1;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_model(input logic [15:0] a);
      return a == 16'h1234 ? 16'hBEEF : a ^ 16'h5A5A;
   endfunction

   genvar g;
   for (g = 0; g < 3; g++) begin : u
      localparam int D = (g == 0) ? 0 : (g == 1) ? 4 : 15;
      logic [1:0]  resp;
      logic [15:0] maddr, mwdata, rdata;
      logic        re, we, busy, ovf;
      int          n_resp = 0, bad_start = 0, min_gap = 100000;
      int          re_cnt = 0, we_cnt = 0, both_cnt = 0, nz_cnt = 0;
      int          phase = 0, gap = 0;
      logic [15:0] sh;
      logic [15:0] words [8];

      serial_mem_responder #(.RESP_DELAY(D)) dut (
         .clk      (clk),
         .reset    (rst_v[g]),
         .cmd_pins (cmd_v[2*g +: 2]),
         .resp_pins(resp),
         .mem_addr (maddr),
         .mem_re   (re),
         .mem_rdata(rdata),
         .mem_we   (we),
         .mem_wdata(mwdata),
         .busy     (busy),
         .overflow (ovf)
      );

      always @(posedge clk) if (re) rdata <= mem_model(maddr);

      always @(negedge clk) begin
         re_cnt   += int'(re);
         we_cnt   += int'(we);
         both_cnt += int'(re && we);
         nz_cnt   += int'(resp != 2'd0);
         if (rst_v[g]) begin
            phase = 0;
            gap   = 0;
         end else if (phase == 0) begin
            if (resp != 2'd0) begin
               if (resp != 2'd1) bad_start++;
               if (gap < min_gap) min_gap = gap;
               phase = 1;
            end else gap++;
         end else begin
            sh = {resp, sh[15:2]};
            if (phase == 8) begin
               words[n_resp % 8] = sh;
               n_resp++;
               phase = 0;
               gap   = 0;
            end else phase++;
         end
      end
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
   } vec_t;
   vec_t vt [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send_cmd(input int k, input logic [1:0] hdr, input logic [15:0] a,
                           input logic [15:0] wd, input bit has_data);
      cmd_v[2*k +: 2] = 2'b11;
      tick();
      cmd_v[2*k +: 2] = hdr;
      tick();
      for (int i = 0; i < 8; i++) begin
         cmd_v[2*k +: 2] = a[2*i +: 2];
         tick();
      end
      if (has_data) begin
         for (int i = 0; i < 8; i++) begin
            cmd_v[2*k +: 2] = wd[2*i +: 2];
            tick();
         end
      end
      cmd_v[2*k +: 2] = 2'b00;
   endtask

   task automatic read_check(input logic [15:0] a, input logic [15:0] exp, input string nm);
      send_cmd(0, 2'd1, a, 16'h0, 1'b0);
      chk({nm, " re at N+1"}, 32'(u[0].re), 32'd1);
      chk({nm, " addr"}, 32'(u[0].maddr), 32'(a));
      chk({nm, " we low"}, 32'(u[0].we), 32'd0);
      tick();
      chk({nm, " re one cycle"}, 32'(u[0].re), 32'd0);
      tick();
      chk({nm, " start at N+3"}, 32'(u[0].resp), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("%s chunk %0d", nm, i), 32'(u[0].resp), 32'(exp[2*i +: 2]));
      end
      tick();
      chk({nm, " pins idle after"}, 32'(u[0].resp), 32'd0);
      chk({nm, " not busy after"}, 32'(u[0].busy), 32'd0);
   endtask

   initial begin
      int re0, we0, nz0;
      vt[0] = '{16'h1234, 16'hBEEF};
      vt[1] = '{16'h0002, 16'h5A58};
      vt[2] = '{16'hFFFF, 16'hA5A5};
      vt[3] = '{16'h0000, 16'h5A5A};

      rst_v = 3'b111;
      repeat (3) tick();
      chk("reset resp0", 32'(u[0].resp), 32'd0);
      chk("reset re0", 32'(u[0].re), 32'd0);
      chk("reset we0", 32'(u[0].we), 32'd0);
      chk("reset ovf0", 32'(u[0].ovf), 32'd0);
      chk("reset busy0", 32'(u[0].busy), 32'd0);
      chk("reset ovf2", 32'(u[2].ovf), 32'd0);
      rst_v = 3'b000;
      tick();

      for (int v = 0; v < 4; v++) read_check(vt[v].a, vt[v].d, $sformatf("read%0d", v));

      re0 = u[0].re_cnt; we0 = u[0].we_cnt; nz0 = u[0].nz_cnt;
      send_cmd(0, 2'd2, 16'h00FE, 16'hA5C3, 1'b1);
      chk("write we", 32'(u[0].we), 32'd1);
      chk("write addr", 32'(u[0].maddr), 32'h00FE);
      chk("write data", 32'(u[0].mwdata), 32'hA5C3);
      chk("write re low", 32'(u[0].re), 32'd0);
      tick();
      chk("write we one cycle", 32'(u[0].we), 32'd0);
      repeat (4) tick();
      chk("write we pulses", 32'(u[0].we_cnt - we0), 32'd1);
      chk("write no re", 32'(u[0].re_cnt - re0), 32'd0);
      chk("write no response", 32'(u[0].nz_cnt - nz0), 32'd0);

      re0 = u[0].re_cnt; we0 = u[0].we_cnt; nz0 = u[0].nz_cnt;
      send_cmd(0, 2'd3, 16'h1111, 16'h0, 1'b0);
      repeat (4) tick();
      chk("unknown hdr no re", 32'(u[0].re_cnt - re0), 32'd0);
      chk("unknown hdr no we", 32'(u[0].we_cnt - we0), 32'd0);
      chk("unknown hdr no response", 32'(u[0].nz_cnt - nz0), 32'd0);
      chk("unknown hdr idle", 32'(u[0].busy), 32'd0);
      read_check(16'h0007, 16'h5A5D, "after unknown");

      send_cmd(0, 2'd1, 16'h0040, 16'h0, 1'b0);
      repeat (5) tick();
      rst_v[0] = 1'b1;
      tick();
      chk("abort pins", 32'(u[0].resp), 32'd0);
      chk("abort busy", 32'(u[0].busy), 32'd0);
      chk("abort ovf", 32'(u[0].ovf), 32'd0);
      rst_v[0] = 1'b0;
      tick();
      read_check(16'h0002, 16'h5A58, "after abort");

      for (int j = 0; j < 3; j++) begin
         send_cmd(1, 2'd1, 16'(16'h0010 * (j + 1)), 16'h0, 1'b0);
         repeat (2) tick();
      end
      repeat (80) tick();
      chk("dly4 responses", 32'(u[1].n_resp), 32'd3);
      chk("dly4 word0", 32'(u[1].words[0]), 32'h5A4A);
      chk("dly4 word1", 32'(u[1].words[1]), 32'h5A7A);
      chk("dly4 word2", 32'(u[1].words[2]), 32'h5A6A);
      chk("dly4 gap>=4", 32'(u[1].min_gap >= 4), 32'd1);
      chk("dly4 start symbol", 32'(u[1].bad_start), 32'd0);
      chk("dly4 ovf", 32'(u[1].ovf), 32'd0);
      chk("dly4 idle", 32'(u[1].busy), 32'd0);

      for (int j = 0; j < 4; j++) begin
         send_cmd(2, 2'd1, 16'(16'h0100 * (j + 1)), 16'h0, 1'b0);
         repeat (2) tick();
         if (j == 2) chk("dly15 ovf after 3rd", 32'(u[2].ovf), 32'd0);
      end
      chk("dly15 ovf after 4th", 32'(u[2].ovf), 32'd1);
      repeat (100) tick();
      chk("dly15 responses", 32'(u[2].n_resp), 32'd3);
      chk("dly15 word0", 32'(u[2].words[0]), 32'h5B5A);
      chk("dly15 word1", 32'(u[2].words[1]), 32'h585A);
      chk("dly15 word2", 32'(u[2].words[2]), 32'h595A);
      chk("dly15 start symbol", 32'(u[2].bad_start), 32'd0);
      chk("dly15 ovf sticky", 32'(u[2].ovf), 32'd1);
      rst_v[2] = 1'b1;
      tick();
      chk("dly15 ovf cleared", 32'(u[2].ovf), 32'd0);
      chk("dly15 idle after reset", 32'(u[2].busy), 32'd0);
      rst_v[2] = 1'b0;
      tick();

      chk("re/we exclusive 0", 32'(u[0].both_cnt), 32'd0);
      chk("re/we exclusive 1", 32'(u[1].both_cnt), 32'd0);
      chk("re/we exclusive 2", 32'(u[2].both_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
